// File: rtl/sram_sp_bist.sv
// March C- BIST initiator for a single-port synchronous SRAM.
// Walks six march elements over every address, compares each read one cycle
// after it is issued, and captures the first miscompare.
module sram_sp_bist #(
   parameter int depth = 10,
   parameter int width = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     fail,
   output logic [$clog2(depth)-1:0] fail_addr,
   output logic [width-1:0]         fail_exp,
   output logic [width-1:0]         fail_got,
   output logic                     mem_we,
   output logic                     mem_re,
   output logic [$clog2(depth)-1:0] mem_add,
   output logic [width-1:0]         mem_data_in,
   input  logic [width-1:0]         mem_data_out
);

   localparam int AW = $clog2(depth);

   typedef enum logic [2:0] {
      S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_FLUSH
   } state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic              wr_q, wr_d;        // 1: write cycle, 0: read cycle
   logic              done_q, done_d;
   logic              cmp_vld_q;
   logic [width-1:0]  cmp_exp_q;
   logic [AW-1:0]     cmp_addr_q;
   logic              fail_q;
   logic [AW-1:0]     fail_addr_q;
   logic [width-1:0]  fail_exp_q;
   logic [width-1:0]  fail_got_q;

   logic              in_march;
   logic              descending;
   logic              rd_ones;
   logic              wr_ones;
   logic              last_op_of_addr;
   logic              at_term;
   logic              accept;

   // Decode element properties: direction and data backgrounds.
   always_comb begin
      in_march   = 1'b0;
      descending = 1'b0;
      rd_ones    = 1'b0;
      wr_ones    = 1'b0;
      case (state_q)
         S_M0: in_march = 1'b1;
         S_M1: begin in_march = 1'b1; wr_ones = 1'b1; end
         S_M2: begin in_march = 1'b1; rd_ones = 1'b1; end
         S_M3: begin in_march = 1'b1; descending = 1'b1; wr_ones = 1'b1; end
         S_M4: begin in_march = 1'b1; descending = 1'b1; rd_ones = 1'b1; end
         S_M5: in_march = 1'b1;
         default: ;
      endcase
   end

   // M0 is write-only and M5 read-only; M1..M4 end each address on the write.
   assign last_op_of_addr = (state_q == S_M0) || (state_q == S_M5) || wr_q;
   assign at_term = descending ? (addr_q == '0) : (addr_q == AW'(depth - 1));
   assign accept  = (state_q == S_IDLE) && start;

   // Next-state: sequence ops within an element, then hop to the next element.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wr_d    = wr_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_M0;
               addr_d  = '0;
               wr_d    = 1'b1;
            end
         end
         S_FLUSH: begin
            state_d = S_IDLE;
            addr_d  = '0;
            wr_d    = 1'b0;
            done_d  = 1'b1;
         end
         default: begin
            if (!last_op_of_addr) begin
               wr_d = 1'b1;
            end else if (!at_term) begin
               addr_d = descending ? (addr_q - AW'(1)) : (addr_q + AW'(1));
               wr_d   = (state_q == S_M0);
            end else begin
               wr_d   = 1'b0;
               addr_d = '0;
               case (state_q)
                  S_M0: state_d = S_M1;
                  S_M1: state_d = S_M2;
                  S_M2: begin state_d = S_M3; addr_d = AW'(depth - 1); end
                  S_M3: begin state_d = S_M4; addr_d = AW'(depth - 1); end
                  S_M4: state_d = S_M5;
                  default: state_d = S_FLUSH;
               endcase
            end
         end
      endcase
   end

   // Sequencer state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
         done_q  <= done_d;
      end
   end

   // Pipeline the expected read value one cycle to line up with mem_data_out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmp_vld_q  <= 1'b0;
         cmp_exp_q  <= '0;
         cmp_addr_q <= '0;
      end else begin
         cmp_vld_q  <= mem_re;
         cmp_exp_q  <= rd_ones ? '1 : '0;
         cmp_addr_q <= addr_q;
      end
   end

   // First-failure capture; cleared only when a new run is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_exp_q  <= '0;
         fail_got_q  <= '0;
      end else if (accept) begin
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_exp_q  <= '0;
         fail_got_q  <= '0;
      end else if (cmp_vld_q && (mem_data_out != cmp_exp_q) && !fail_q) begin
         fail_q      <= 1'b1;
         fail_addr_q <= cmp_addr_q;
         fail_exp_q  <= cmp_exp_q;
         fail_got_q  <= mem_data_out;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign fail        = fail_q;
   assign fail_addr   = fail_addr_q;
   assign fail_exp    = fail_exp_q;
   assign fail_got    = fail_got_q;
   assign mem_we      = in_march && wr_q;
   assign mem_re      = in_march && !wr_q;
   assign mem_add     = addr_q;
   assign mem_data_in = (mem_we && wr_ones) ? '1 : '0;

endmodule

// File: tb/tb_sram_sp_bist.sv
// Bench for sram_sp_bist: two instances (10x8 and 16x4) each driving a
// behavioural SRAM with an optional stuck-at-0 bit, checked against a
// March C- reference model built from the element table.
module tb_sram_sp_bist;

   localparam int D0 = 10;
   localparam int W0 = 8;
   localparam int D1 = 16;
   localparam int W1 = 4;

   logic clk;
   logic rst_n;

   // instance 0 signals
   logic          start0, busy0, done0, fail0, we0, re0;
   logic [3:0]    fail_addr0, add0;
   logic [W0-1:0] fail_exp0, fail_got0, din0, dout0;
   // instance 1 signals
   logic          start1, busy1, done1, fail1, we1, re1;
   logic [3:0]    fail_addr1, add1;
   logic [W1-1:0] fail_exp1, fail_got1, din1, dout1;

   int checks;
   int errors;

   // fault injection: stuck-at-0 bits at one address
   int            f0_addr, f1_addr;
   logic [W0-1:0] f0_mask;
   logic [W1-1:0] f1_mask;
   logic [W0-1:0] mem0 [D0];
   logic [W1-1:0] mem1 [D1];

   sram_sp_bist #(.depth(D0), .width(W0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
      .fail(fail0), .fail_addr(fail_addr0), .fail_exp(fail_exp0),
      .fail_got(fail_got0), .mem_we(we0), .mem_re(re0), .mem_add(add0),
      .mem_data_in(din0), .mem_data_out(dout0));

   sram_sp_bist #(.depth(D1), .width(W1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
      .fail(fail1), .fail_addr(fail_addr1), .fail_exp(fail_exp1),
      .fail_got(fail_got1), .mem_we(we1), .mem_re(re1), .mem_add(add1),
      .mem_data_in(din1), .mem_data_out(dout1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM models: write commits at the edge, read data valid after the edge
   always @(posedge clk) begin
      if (we0 && int'(add0) < D0)
         mem0[add0] <= (int'(add0) == f0_addr) ? (din0 & ~f0_mask) : din0;
      if (re0 && int'(add0) < D0)
         dout0 <= mem0[add0];
   end

   always @(posedge clk) begin
      if (we1)
         mem1[add1] <= (int'(add1) == f1_addr) ? (din1 & ~f1_mask) : din1;
      if (re1)
         dout1 <= mem1[add1];
   end

   // March C- element table: direction, read?, read value, write?, write value
   int el_desc [6] = '{0, 0, 0, 1, 1, 0};
   int el_rd   [6] = '{0, 1, 1, 1, 1, 1};
   int el_rv   [6] = '{0, 0, 1, 0, 1, 0};
   int el_wr   [6] = '{1, 1, 1, 1, 1, 0};
   int el_wv   [6] = '{0, 1, 0, 1, 0, 0};

   int exp_op [200];
   int n_ops;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // expected per-cycle bus activity packed as we<<20 | re<<16 | add<<8 | din
   task automatic build_ops(input int depth, input int width);
      int all;
      int a;
      all   = (1 << width) - 1;
      n_ops = 0;
      for (int e = 0; e < 6; e++) begin
         for (int i = 0; i < depth; i++) begin
            a = (el_desc[e] != 0) ? depth - 1 - i : i;
            if (el_rd[e] != 0) begin
               exp_op[n_ops] = (1 << 16) | (a << 8);
               n_ops++;
            end
            if (el_wr[e] != 0) begin
               exp_op[n_ops] = (1 << 20) | (a << 8) | ((el_wv[e] != 0) ? all : 0);
               n_ops++;
            end
         end
      end
   endtask

   // first miscompare of a full March C- over a memory with stuck-at-0 bit fb at fa
   task automatic predict(input int depth, input int width, input int fa, input int fb,
                          output int pf, output int pa, output int pe, output int pg);
      int m [32];
      int all;
      int a;
      int ev;
      int v;
      all = (1 << width) - 1;
      pf = 0; pa = 0; pe = 0; pg = 0;
      for (int i = 0; i < 32; i++) m[i] = 0;
      for (int e = 0; e < 6; e++) begin
         for (int i = 0; i < depth; i++) begin
            a = (el_desc[e] != 0) ? depth - 1 - i : i;
            if (el_rd[e] != 0) begin
               ev = (el_rv[e] != 0) ? all : 0;
               if (m[a] != ev && pf == 0) begin
                  pf = 1; pa = a; pe = ev; pg = m[a];
               end
            end
            if (el_wr[e] != 0) begin
               v = (el_wv[e] != 0) ? all : 0;
               if (a == fa) v = v & ~(1 << fb);
               m[a] = v;
            end
         end
      end
   endtask

   // one run on instance 0; pa/pb are cycles at which start is re-pulsed
   task automatic run0(input int pa, input int pb, input bit chk_trace, output int done_k);
      int busy_n;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      check("fail_clear_on_start", {31'd0, fail0}, 0);
      done_k = -1;
      busy_n = 0;
      for (int k = 0; k <= 10 * D0 + 10; k++) begin
         if (done0) begin
            done_k = k;
            break;
         end
         if (busy0) busy_n++;
         if (chk_trace) begin
            if (k < n_ops)
               check($sformatf("trace%0d", k),
                     {11'd0, we0, 3'd0, re0, 4'd0, add0, din0}, exp_op[k]);
            check("we_re_exclusive", {31'd0, we0 & re0}, 0);
         end
         start0 = (k == pa || k == pb);
         @(negedge clk);
      end
      start0 = 1'b0;
      check("done_time0", done_k, 10 * D0 + 1);
      check("busy_cycles0", busy_n, 10 * D0 + 1);
      check("busy_low_at_done0", {31'd0, busy0}, 0);
      @(negedge clk);
      check("done_one_cycle0", {31'd0, done0}, 0);
   endtask

   task automatic run1(output int done_k);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      done_k = -1;
      for (int k = 0; k <= 10 * D1 + 10; k++) begin
         if (done1) begin
            done_k = k;
            break;
         end
         @(negedge clk);
      end
      check("done_time1", done_k, 10 * D1 + 1);
      @(negedge clk);
   endtask

   int dk, n, fa, fb, pf, pa, pe, pg;

   initial begin
      checks = 0; errors = 0;
      start0 = 1'b0; start1 = 1'b0; rst_n = 1'b0;
      f0_addr = -1; f0_mask = '0; f1_addr = -1; f1_mask = '0;
      build_ops(D0, W0);

      // reset state
      #12;
      check("rst_ctrl0", {26'd0, busy0, done0, fail0, we0, re0, 1'b0}, 0);
      check("rst_add0", {28'd0, add0}, 0);
      check("rst_din0", {24'd0, din0}, 0);
      check("rst_fail_info0", {12'd0, fail_addr0, fail_exp0, fail_got0}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // clean run with ignored restarts at cycles 5 and 50, full trace check
      run0(5, 50, 1'b1, dk);
      check("clean_fail0", {31'd0, fail0}, 0);
      for (int i = 0; i < D0; i++)
         check($sformatf("final_mem%0d", i), {24'd0, mem0[i]}, 0);

      // stuck-at-0 on bit0 of address 3
      f0_addr = 3; f0_mask = 8'h01;
      run0(-1, -1, 1'b0, dk);
      check("sa0_fail", {31'd0, fail0}, 1);
      check("sa0_addr", {28'd0, fail_addr0}, 3);
      check("sa0_exp", {24'd0, fail_exp0}, 32'hFF);
      check("sa0_got", {24'd0, fail_got0}, 32'hFE);
      repeat (3) @(negedge clk);
      check("sa0_fail_sticky", {31'd0, fail0}, 1);

      // random single stuck-at-0 faults against the reference model
      for (int r = 0; r < 4; r++) begin
         fa = $urandom_range(0, D0 - 1);
         fb = $urandom_range(0, W0 - 1);
         f0_addr = fa; f0_mask = W0'(1 << fb);
         predict(D0, W0, fa, fb, pf, pa, pe, pg);
         run0(-1, -1, 1'b0, dk);
         check($sformatf("rnd%0d_fail", r), {31'd0, fail0}, pf);
         check($sformatf("rnd%0d_info", r), {12'd0, fail_addr0, fail_exp0, fail_got0},
               (pa << 16) | (pe << 8) | pg);
      end

      // reset at cycle 40 of a failing run
      f0_addr = 3; f0_mask = 8'h01;
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (40) @(negedge clk);
      check("pre_rst_fail", {31'd0, fail0}, 1);
      rst_n = 1'b0;
      #1;
      check("async_rst_ctrl", {26'd0, busy0, done0, fail0, we0, re0, 1'b0}, 0);
      check("async_rst_bus", {20'd0, add0, din0}, 0);
      check("async_rst_fail_info", {12'd0, fail_addr0, fail_exp0, fail_got0}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      f0_addr = -1; f0_mask = '0;
      n = 0;
      for (int k = 0; k < 10 * D0 + 5; k++) begin
         if (done0) n++;
         @(negedge clk);
      end
      check("no_done_after_rst", n, 0);
      run0(-1, -1, 1'b0, dk);
      check("post_rst_fail", {31'd0, fail0}, 0);

      // start held high: back-to-back runs
      start0 = 1'b1;
      n = 0;
      while (!done0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("b2b_first_done", {31'd0, done0}, 1);
      @(negedge clk);
      check("b2b_restart_busy", {30'd0, busy0, done0}, 2);
      n = 1;
      while (!done0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      start0 = 1'b0;
      check("b2b_period", n, 10 * D0 + 2);
      @(negedge clk);
      check("b2b_idle", {31'd0, busy0}, 0);

      // 16x4 instance: clean run, then a random fault
      run1(dk);
      check("clean_fail1", {31'd0, fail1}, 0);
      fa = $urandom_range(0, D1 - 1);
      fb = $urandom_range(0, W1 - 1);
      f1_addr = fa; f1_mask = W1'(1 << fb);
      predict(D1, W1, fa, fb, pf, pa, pe, pg);
      run1(dk);
      check("rnd1_fail", {31'd0, fail1}, pf);
      check("rnd1_info", {20'd0, fail_addr1, fail_exp1, fail_got1},
            (pa << 8) | (pe << 4) | pg);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
